lcd_rgb: RTL and testbench

LCD_RGB -- requirements
Module: lcd_rgb

---
 rtl/lcd_rgb.sv | 143 ++++++++++++++
 tb/tb_lcd_rgb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb.sv
// Game-boy style shade-to-RGB converter: a two-stage pipeline that maps 2-bit
// LCD shades to 6-bit colours and tracks pixel coordinates alongside them.
module lcd_rgb #(
    parameter int LAT = 2
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic [1:0] pixel,
    input  logic       active,
    input  logic       hs,
    input  logic       vs,
    input  logic       tint,
    input  logic       scanlines,
    output logic [5:0] r,
    output logic [5:0] g,
    output logic [5:0] b,
    output logic       hs_o,
    output logic       vs_o,
    output logic       de_o,
    output logic [7:0] x,
    output logic [9:0] y
);

    logic [1:0]     pix1_q;
    logic           act1_q;
    logic [7:0]     x1_q;
    logic [9:0]     y1_q;
    logic [7:0]     colCnt_q, colCnt_d;
    logic [9:0]     lineCnt_q, lineCnt_d;
    logic           prevAct_q, prevVs_q;
    logic           tintL_q, scanL_q;
    logic [LAT-1:0] hsDly_q, vsDly_q;
    logic [5:0]     rOut_q, gOut_q, bOut_q;
    logic           deOut_q;
    logic [7:0]     xOut_q;
    logic [9:0]     yOut_q;
    logic [5:0]     rPal, gPal, bPal;
    logic           vsRise, actFall;

    assign vsRise  = vs & ~prevVs_q;
    assign actFall = prevAct_q & ~active;

    // A vs rise restarts the frame even when it coincides with a line end.
    always_comb begin
        colCnt_d  = 8'd0;
        lineCnt_d = lineCnt_q;
        if (active) begin
            colCnt_d = (colCnt_q == 8'hFF) ? colCnt_q : colCnt_q + 8'd1;
        end
        if (vsRise) begin
            lineCnt_d = 10'd0;
        end else if (actFall && (lineCnt_q != 10'h3FF)) begin
            lineCnt_d = lineCnt_q + 10'd1;
        end
    end

    always_comb begin
        rPal = 6'd0;
        gPal = 6'd0;
        bPal = 6'd0;
        if (tintL_q) begin
            case (pix1_q)
                2'd0:    begin rPal = 6'd38; gPal = 6'd47; bPal = 6'd3;  end
                2'd1:    begin rPal = 6'd34; gPal = 6'd43; bPal = 6'd3;  end
                2'd2:    begin rPal = 6'd12; gPal = 6'd24; bPal = 6'd12; end
                default: begin rPal = 6'd3;  gPal = 6'd14; bPal = 6'd3;  end
            endcase
        end else begin
            case (pix1_q)
                2'd0:    rPal = 6'd63;
                2'd1:    rPal = 6'd42;
                2'd2:    rPal = 6'd21;
                default: rPal = 6'd0;
            endcase
            gPal = rPal;
            bPal = rPal;
        end
        if (scanL_q && y1_q[0]) begin
            rPal = rPal >> 1;
            gPal = gPal >> 1;
            bPal = bPal >> 1;
        end
        if (!act1_q) begin
            rPal = 6'd0;
            gPal = 6'd0;
            bPal = 6'd0;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix1_q    <= 2'd0;
            act1_q    <= 1'b0;
            x1_q      <= 8'd0;
            y1_q      <= 10'd0;
            colCnt_q  <= 8'd0;
            lineCnt_q <= 10'd0;
            prevAct_q <= 1'b0;
            prevVs_q  <= 1'b0;
            tintL_q   <= 1'b0;
            scanL_q   <= 1'b0;
            hsDly_q   <= '1;
            vsDly_q   <= '0;
            rOut_q    <= 6'd0;
            gOut_q    <= 6'd0;
            bOut_q    <= 6'd0;
            deOut_q   <= 1'b0;
            xOut_q    <= 8'd0;
            yOut_q    <= 10'd0;
        end else begin
            pix1_q    <= pixel;
            act1_q    <= active;
            x1_q      <= active ? colCnt_q : 8'd0;
            y1_q      <= lineCnt_q;
            colCnt_q  <= colCnt_d;
            lineCnt_q <= lineCnt_d;
            prevAct_q <= active;
            prevVs_q  <= vs;
            if (vsRise) begin
                tintL_q <= tint;
                scanL_q <= scanlines;
            end
            hsDly_q   <= {hsDly_q[LAT-2:0], hs};
            vsDly_q   <= {vsDly_q[LAT-2:0], vs};
            rOut_q    <= rPal;
            gOut_q    <= gPal;
            bOut_q    <= bPal;
            deOut_q   <= act1_q;
            xOut_q    <= x1_q;
            yOut_q    <= y1_q;
        end
    end

    assign r    = rOut_q;
    assign g    = gOut_q;
    assign b    = bOut_q;
    assign de_o = deOut_q;
    assign x    = xOut_q;
    assign y    = yOut_q;
    assign hs_o = hsDly_q[LAT-1];
    assign vs_o = vsDly_q[LAT-1];

endmodule

// File: tb/tb_lcd_rgb.sv
// Directed bench for lcd_rgb: every output is checked two cycles after the
// input sample that produced it, against hand-derived palette and coordinate values.
module tb_lcd_rgb;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic [1:0] pixel;
    logic       active, hs, vs, tint, scanlines;
    logic [5:0] r, g, b;
    logic       hs_o, vs_o, de_o;
    logic [7:0] x;
    logic [9:0] y;

    lcd_rgb #(.LAT(2)) dut (
        .pclk(pclk), .rst_n(rst_n), .pixel(pixel), .active(active), .hs(hs), .vs(vs),
        .tint(tint), .scanlines(scanlines), .r(r), .g(g), .b(b),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .x(x), .y(y)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic de, hs, vs;
        int   r, g, b, x, y;
    } expT;

    typedef struct {
        logic       act;
        logic [1:0] pix;
        logic       h, v, t, s;
        int         r, g, b, x, y;
    } vecT;

    expT expQ[$];
    vecT tbl[21];
    int  nCompared = 0;
    int  nMismatched = 0;
    int  grey[4] = '{63, 42, 21, 0};

    function automatic expT mkExp(input logic de, input logic h, input logic v,
                                  input int er, input int eg, input int eb,
                                  input int ex, input int ey);
        expT e;
        e.de = de; e.hs = h; e.vs = v;
        e.r = er; e.g = eg; e.b = eb; e.x = ex; e.y = ey;
        return e;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input expT e);
        checkVal("de_o", int'(de_o), int'(e.de));
        checkVal("hs_o", int'(hs_o), int'(e.hs));
        checkVal("vs_o", int'(vs_o), int'(e.vs));
        checkVal("r", int'(r), e.r);
        checkVal("g", int'(g), e.g);
        checkVal("b", int'(b), e.b);
        checkVal("x", int'(x), e.x);
        checkVal("y", int'(y), e.y);
    endtask

    task automatic checkReset(input string tag);
        $display("[TB] checking reset values: %s", tag);
        checkOutput(mkExp(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0));
    endtask

    // Outputs seen at a falling edge belong to the sample driven two falling edges earlier.
    task automatic applyStimulus(input logic a, input logic [1:0] p, input logic h,
                                 input logic v, input logic t, input logic s, input expT e);
        @(negedge pclk);
        if (expQ.size() == 2) checkOutput(expQ.pop_front());
        active = a; pixel = p; hs = h; vs = v; tint = t; scanlines = s;
        expQ.push_back(e);
    endtask

    task automatic idleCycle(input logic h, input logic v, input logic t, input int yExp);
        applyStimulus(1'b0, 2'd3, h, v, t, 1'b0, mkExp(1'b0, h, v, 0, 0, 0, 0, yExp));
    endtask

    task automatic activeCycle(input logic [1:0] p, input logic t, input int er, input int eg,
                               input int eb, input int xExp, input int yExp);
        applyStimulus(1'b1, p, 1'b1, 1'b0, t, 1'b0, mkExp(1'b1, 1'b1, 1'b0, er, eg, eb, xExp, yExp));
    endtask

    initial begin
        rst_n = 1'b0; active = 1'b0; pixel = 2'd0; hs = 1'b1; vs = 1'b0;
        tint = 1'b0; scanlines = 1'b0;
        #12;
        checkReset("power-on");
        @(negedge pclk);
        rst_n = 1'b1;

        // {act, pix, hs, vs, tint, scan, r, g, b, x, y}
        tbl[0]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1,  0,  0,  0, 0, 0};
        tbl[1]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 63, 63, 63, 0, 0};
        tbl[2]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 42, 42, 42, 1, 0};
        tbl[3]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 21, 21, 21, 2, 0};
        tbl[4]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1,  0,  0,  0, 3, 0};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1,  0,  0,  0, 0, 0};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1,  0,  0,  0, 0, 1};
        tbl[7]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 31, 31, 31, 0, 1};
        tbl[8]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 21, 21, 21, 1, 1};
        tbl[9]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 10, 10, 10, 2, 1};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1,  0,  0,  0, 0, 1};
        tbl[11] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 63, 63, 63, 0, 2};
        tbl[12] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1,  0,  0,  0, 1, 2};
        tbl[13] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0,  0,  0,  0, 0, 2};
        tbl[14] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 38, 47,  3, 0, 0};
        tbl[15] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 34, 43,  3, 1, 0};
        tbl[16] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 12, 24, 12, 2, 0};
        tbl[17] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1,  3, 14,  3, 3, 0};
        tbl[18] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0,  0,  0,  0, 0, 0};
        tbl[19] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0,  3, 14,  3, 0, 1};
        tbl[20] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0,  0,  0,  0, 0, 1};
        for (int i = 0; i < 21; i++) begin
            applyStimulus(tbl[i].act, tbl[i].pix, tbl[i].h, tbl[i].v, tbl[i].t, tbl[i].s,
                          mkExp(tbl[i].act, tbl[i].h, tbl[i].v, tbl[i].r, tbl[i].g,
                                tbl[i].b, tbl[i].x, tbl[i].y));
        end

        $display("[TB] 160-pixel grey line");
        idleCycle(1'b1, 1'b1, 1'b0, 2);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 160; i++)
            activeCycle(2'(i % 4), 1'b0, grey[i % 4], grey[i % 4], grey[i % 4], i, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 1);

        $display("[TB] tint is frame-latched");
        idleCycle(1'b1, 1'b1, 1'b1, 1);
        idleCycle(1'b1, 1'b0, 1'b1, 0);
        for (int i = 0; i < 20; i++)
            activeCycle(2'd2, (i < 10) ? 1'b1 : 1'b0, 12, 24, 12, i, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) activeCycle(2'd2, 1'b0, 12, 24, 12, i, 1);
        idleCycle(1'b1, 1'b0, 1'b0, 1);
        idleCycle(1'b1, 1'b0, 1'b0, 2);
        idleCycle(1'b1, 1'b1, 1'b0, 2);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) activeCycle(2'd2, 1'b0, 21, 21, 21, i, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 1);

        $display("[TB] column saturation");
        idleCycle(1'b1, 1'b1, 1'b0, 1);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 300; i++) activeCycle(2'd1, 1'b0, 42, 42, 42, (i < 255) ? i : 255, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 1);

        $display("[TB] vs rise on a line end");
        idleCycle(1'b1, 1'b1, 1'b0, 1);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        for (int l = 0; l < 6; l++) begin
            for (int k = 0; k < 4; k++) activeCycle(2'(k), 1'b0, grey[k], grey[k], grey[k], k, l);
            idleCycle(1'b0, (l == 5) ? 1'b1 : 1'b0, 1'b0, l);
            idleCycle(1'b0, 1'b0, 1'b0, (l == 5) ? 0 : l + 1);
        end
        for (int k = 0; k < 4; k++) activeCycle(2'(k), 1'b0, grey[k], grey[k], grey[k], k, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 1);

        $display("[TB] reset in the middle of a line");
        idleCycle(1'b1, 1'b1, 1'b0, 1);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) activeCycle(2'd0, 1'b0, 63, 63, 63, i, 0);
        #2;
        checkVal("de_o before reset", int'(de_o), 1);
        rst_n = 1'b0;
        #1;
        checkReset("mid-line assert");
        expQ.delete();
        active = 1'b0; pixel = 2'd0; hs = 1'b1; vs = 1'b0; tint = 1'b0; scanlines = 1'b0;
        @(negedge pclk);
        checkReset("held");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) activeCycle(2'(i % 4), 1'b0, grey[i % 4], grey[i % 4], grey[i % 4], i, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 0);
        idleCycle(1'b1, 1'b0, 1'b0, 1);
        idleCycle(1'b1, 1'b0, 1'b0, 1);
        idleCycle(1'b1, 1'b0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
